axi_rd_arbiter: RTL and testbench

- Arbitrates cache-refill and uncached read requests from the ICache (port 0) and the DCache (port 1) onto one AXI3-style read address and read data channel pair.
- Sits between the two caches and the AXI bridge.
- Exactly one read transaction is outstanding at a time.
- Returned beats are routed back to the requester by RID.

---
 rtl/axi_rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi_rd_arbiter                                             |
// | Description : Two-port (ICache = port 0, DCache = port 1) read arbiter   |
// |               onto one AXI3-style AR/R channel pair. One transaction is  |
// |               outstanding at a time, and return beats are routed by RID. |
// |               Define RD_ARB_RR_EN for round-robin arbitration. The       |
// |               default is fixed priority, with data over inst.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axi_rd_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  // ICache port
  input  logic              inst_rd_req,
  input  logic              inst_rd_type,
  input  logic [ADDR_W-1:0] inst_rd_addr,
  output logic              inst_rd_rdy,
  output logic              inst_ret_valid,
  output logic              inst_ret_last,
  output logic [31:0]       inst_ret_data,
  // DCache port
  input  logic              data_rd_req,
  input  logic              data_rd_type,
  input  logic [ADDR_W-1:0] data_rd_addr,
  output logic              data_rd_rdy,
  output logic              data_ret_valid,
  output logic              data_ret_last,
  output logic [31:0]       data_ret_data,
  // AXI read address channel
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data channel
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // status
  output logic              busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_AR   = 2'd1;
  localparam logic [1:0] c_R    = 2'd2;

  localparam logic [3:0] c_ID_INST = 4'd0;
  localparam logic [3:0] c_ID_DATA = 4'd1;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_araddr;
  logic [3:0]        r_arid;
  logic [7:0]        r_arlen;
  logic [7:0]        r_beat_cnt;

  logic              w_grant_data;
  logic              w_line;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ar_hs;
  logic              w_beat_match;

`ifdef RD_ARB_RR_EN
  // 1 = data was granted last; reset points at inst so data wins the first tie
  logic r_last_grant;

  // Remember which port won the most recent arbitration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
    end else if (r_state == c_IDLE && (inst_rd_req || data_rd_req)) begin
      r_last_grant <= w_grant_data;
    end
  end

  // On a tie, the port that was not granted last wins
  always_comb begin
    w_grant_data = data_rd_req && (!inst_rd_req || !r_last_grant);
  end
`else
  // Fixed priority: data always wins a tie
  always_comb begin
    w_grant_data = data_rd_req;
  end
`endif

  // Select the winner's request fields and work out the AR handshake and matching beats
  always_comb begin
    w_line       = w_grant_data ? data_rd_type : inst_rd_type;
    w_addr       = w_grant_data ? data_rd_addr : inst_rd_addr;
    w_ar_hs      = (r_state == c_AR) && arready;
    w_beat_match = (r_state == c_R) && rvalid && (rid == r_arid);
  end

  // Transaction FSM: latch the request in IDLE, hold AR until ready, drain R until matching rlast
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_araddr   <= '0;
      r_arid     <= 4'd0;
      r_arlen    <= 8'd0;
      r_beat_cnt <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (inst_rd_req || data_rd_req) begin
            // Line refills are aligned to the 16-byte line
            r_araddr <= w_line ? {w_addr[ADDR_W-1:4], 4'b0000} : w_addr;
            r_arlen  <= w_line ? 8'(BURST_LEN - 1) : 8'd0;
            r_arid   <= w_grant_data ? c_ID_DATA : c_ID_INST;
            r_state  <= c_AR;
          end
        end
        c_AR: begin
          if (arready) begin
            r_beat_cnt <= 8'd0;
            r_state    <= c_R;
          end
        end
        c_R: begin
          // Every beat is accepted; beats with a foreign RID are dropped
          if (rvalid) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          // Only rlast from our own ID ends the transaction, whatever the beat count
          if (w_beat_match && rlast) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // AR channel fields come straight from the latched request
  always_comb begin
    arvalid = (r_state == c_AR);
    araddr  = r_araddr;
    arlen   = r_arlen;
    arid    = r_arid;
    arsize  = 3'b010;
    arburst = 2'b01;
    rready  = (r_state == c_R);
    busy    = (r_state != c_IDLE);
  end

  // Acknowledge the granted requester and route return beats by RID
  always_comb begin
    inst_rd_rdy    = w_ar_hs && (r_arid == c_ID_INST);
    data_rd_rdy    = w_ar_hs && (r_arid == c_ID_DATA);
    inst_ret_valid = w_beat_match && (r_arid == c_ID_INST);
    data_ret_valid = w_beat_match && (r_arid == c_ID_DATA);
    inst_ret_last  = inst_ret_valid && rlast;
    data_ret_last  = data_ret_valid && rlast;
    inst_ret_data  = rdata;
    data_ret_data  = rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axi_rd_arbiter                                          |
// | Description : Cycle-by-cycle vector bench for axi_rd_arbiter. Each       |
// |               record gives one cycle's inputs and the outputs expected   |
// |               in that same cycle. Build with RD_ARB_RR_EN to get the     |
// |               round-robin expectations.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, inst_rd_type, inst_rd_rdy, inst_ret_valid, inst_ret_last;
  logic [31:0] inst_rd_addr, inst_ret_data;
  logic        data_rd_req, data_rd_type, data_rd_rdy, data_ret_valid, data_ret_last;
  logic [31:0] data_rd_addr, data_ret_data;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready, rlast, rvalid, rready, busy;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter #(.BURST_LEN(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .data_ret_data(data_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    // inputs
    logic        ir; logic it; logic [31:0] ia;
    logic        dr; logic dt; logic [31:0] da;
    logic        arr; logic rv; logic [3:0] rid; logic [31:0] rd; logic rl;
    // expected outputs
    logic        e_arv; logic [31:0] e_ara; logic [7:0] e_arl; logic [3:0] e_arid;
    logic        e_irdy; logic e_drdy;
    logic        e_irv; logic e_irl; logic e_drv; logic e_drl;
    logic        e_rr; logic e_busy;
  } vec_t;

  function automatic vec_t mk(
      input logic ir, input logic it, input logic [31:0] ia,
      input logic dr, input logic dt, input logic [31:0] da,
      input logic arr, input logic rv, input logic [3:0] rd_id, input logic [31:0] rd, input logic rl,
      input logic e_arv, input logic [31:0] e_ara, input logic [7:0] e_arl, input logic [3:0] e_arid,
      input logic e_irdy, input logic e_drdy,
      input logic e_irv, input logic e_irl, input logic e_drv, input logic e_drl,
      input logic e_rr, input logic e_busy);
    vec_t v;
    v.ir = ir; v.it = it; v.ia = ia; v.dr = dr; v.dt = dt; v.da = da;
    v.arr = arr; v.rv = rv; v.rid = rd_id; v.rd = rd; v.rl = rl;
    v.e_arv = e_arv; v.e_ara = e_ara; v.e_arl = e_arl; v.e_arid = e_arid;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy;
    v.e_irv = e_irv; v.e_irl = e_irl; v.e_drv = e_drv; v.e_drl = e_drl;
    v.e_rr = e_rr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the next edge
  task automatic apply(input vec_t v, input string tag);
    inst_rd_req = v.ir; inst_rd_type = v.it; inst_rd_addr = v.ia;
    data_rd_req = v.dr; data_rd_type = v.dt; data_rd_addr = v.da;
    arready = v.arr; rvalid = v.rv; rid = v.rid; rdata = v.rd; rlast = v.rl;
    @(negedge clk);
    chk({tag, " arvalid"}, 32'(arvalid), 32'(v.e_arv));
    if (v.e_arv) begin
      chk({tag, " araddr"},  araddr,       v.e_ara);
      chk({tag, " arlen"},   32'(arlen),   32'(v.e_arl));
      chk({tag, " arid"},    32'(arid),    32'(v.e_arid));
      chk({tag, " arsize"},  32'(arsize),  32'h2);
      chk({tag, " arburst"}, 32'(arburst), 32'h1);
    end
    chk({tag, " inst_rd_rdy"},    32'(inst_rd_rdy),    32'(v.e_irdy));
    chk({tag, " data_rd_rdy"},    32'(data_rd_rdy),    32'(v.e_drdy));
    chk({tag, " inst_ret_valid"}, 32'(inst_ret_valid), 32'(v.e_irv));
    chk({tag, " data_ret_valid"}, 32'(data_ret_valid), 32'(v.e_drv));
    if (v.e_irv) begin
      chk({tag, " inst_ret_last"}, 32'(inst_ret_last), 32'(v.e_irl));
      chk({tag, " inst_ret_data"}, inst_ret_data,      v.rd);
    end
    if (v.e_drv) begin
      chk({tag, " data_ret_last"}, 32'(data_ret_last), 32'(v.e_drl));
      chk({tag, " data_ret_data"}, data_ret_data,      v.rd);
    end
    chk({tag, " rready"}, 32'(rready), 32'(v.e_rr));
    chk({tag, " busy"},   32'(busy),   32'(v.e_busy));
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A_I  = 32'hBFC0_0014;
  localparam logic [31:0] A_IL = 32'hBFC0_0010;
  localparam logic [31:0] A_D  = 32'h8000_0008;
  localparam logic [31:0] A_S  = 32'h8000_0124;
  localparam logic [31:0] A_SL = 32'h8000_0120;
  localparam logic [31:0] A_X  = 32'h8000_0100;
  localparam logic [31:0] A_N  = 32'h1000_0004;
  localparam logic [31:0] A_RI = 32'h0000_3008;
  localparam logic [31:0] A_RD = 32'h0000_4004;

  vec_t tbl[15];

  initial begin
    logic rr_inst_first;
`ifdef RD_ARB_RR_EN
    rr_inst_first = 1'b1;
`else
    rr_inst_first = 1'b0;
`endif

    // Inst line read, then a data/inst tie (data wins), then inst with early rlast
    tbl[0]  = mk(1,1,A_I, 0,0,0, 1, 0,0,0,0,       0,0,0,0,    0,0, 0,0,0,0, 0,0);
    tbl[1]  = mk(1,1,A_I, 0,0,0, 1, 0,0,0,0,       1,A_IL,3,0, 1,0, 0,0,0,0, 0,1);
    tbl[2]  = mk(0,0,0,   0,0,0, 0, 1,0,32'h11,0,  0,0,0,0,    0,0, 1,0,0,0, 1,1);
    tbl[3]  = mk(0,0,0,   0,0,0, 0, 1,0,32'h22,0,  0,0,0,0,    0,0, 1,0,0,0, 1,1);
    tbl[4]  = mk(0,0,0,   0,0,0, 0, 1,0,32'h33,0,  0,0,0,0,    0,0, 1,0,0,0, 1,1);
    tbl[5]  = mk(0,0,0,   0,0,0, 0, 1,0,32'h44,1,  0,0,0,0,    0,0, 1,1,0,0, 1,1);
    tbl[6]  = mk(0,0,0,   0,0,0, 0, 1,0,32'h99,0,  0,0,0,0,    0,0, 0,0,0,0, 0,0);
    tbl[7]  = mk(1,1,A_I, 1,0,A_D, 1, 0,0,0,0,     0,0,0,0,    0,0, 0,0,0,0, 0,0);
    tbl[8]  = mk(1,1,A_I, 1,0,A_D, 1, 0,0,0,0,     1,A_D,0,1,  0,1, 0,0,0,0, 0,1);
    tbl[9]  = mk(1,1,A_I, 0,0,0, 0, 1,1,32'h55,1,  0,0,0,0,    0,0, 0,0,1,1, 1,1);
    tbl[10] = mk(1,1,A_I, 0,0,0, 1, 0,0,0,0,       0,0,0,0,    0,0, 0,0,0,0, 0,0);
    tbl[11] = mk(1,1,A_I, 0,0,0, 1, 0,0,0,0,       1,A_IL,3,0, 1,0, 0,0,0,0, 0,1);
    tbl[12] = mk(0,0,0,   0,0,0, 0, 1,0,32'h66,0,  0,0,0,0,    0,0, 1,0,0,0, 1,1);
    tbl[13] = mk(0,0,0,   0,0,0, 0, 1,0,32'h77,1,  0,0,0,0,    0,0, 1,1,0,0, 1,1);
    tbl[14] = mk(0,0,0,   0,0,0, 0, 0,0,0,0,       0,0,0,0,    0,0, 0,0,0,0, 0,0);

    reset = 1'b1;
    inst_rd_req = 0; inst_rd_type = 0; inst_rd_addr = 0;
    data_rd_req = 0; data_rd_type = 0; data_rd_addr = 0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rlast = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset arvalid", 32'(arvalid), 0);
    chk("reset rready",  32'(rready),  0);
    chk("reset busy",    32'(busy),    0);
    chk("reset rdy",     32'({inst_rd_rdy, data_rd_rdy}), 0);
    chk("reset retv",    32'({inst_ret_valid, data_ret_valid, inst_ret_last, data_ret_last}), 0);
    chk("reset araddr",  araddr, 0);
    chk("reset arid",    32'(arid), 0);
    chk("reset arlen",   32'(arlen), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // AR stall for 5 cycles, then stray-RID beats inside a data line read
    apply(mk(0,0,0, 1,1,A_S, 0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0), "stall idle");
    for (int k = 0; k < 5; k++) begin
      apply(mk(0,0,0, 1,1,A_S, 0, 0,0,0,0, 1,A_SL,3,1, 0,0, 0,0,0,0, 0,1), $sformatf("stall%0d", k));
    end
    apply(mk(0,0,0, 1,1,A_S, 1, 0,0,0,0,          1,A_SL,3,1, 0,1, 0,0,0,0, 0,1), "stall hs");
    apply(mk(0,0,0, 0,0,0,   0, 1,0,32'hAA,0,     0,0,0,0,    0,0, 0,0,0,0, 1,1), "stray1");
    apply(mk(0,0,0, 0,0,0,   0, 1,1,32'hBB,0,     0,0,0,0,    0,0, 0,0,1,0, 1,1), "dbeat1");
    apply(mk(0,0,0, 0,0,0,   0, 1,0,32'hAB,1,     0,0,0,0,    0,0, 0,0,0,0, 1,1), "stray last");
    apply(mk(0,0,0, 0,0,0,   0, 1,1,32'hCC,1,     0,0,0,0,    0,0, 0,0,1,1, 1,1), "dbeat last");
    apply(mk(0,0,0, 0,0,0,   0, 0,0,0,0,          0,0,0,0,    0,0, 0,0,0,0, 0,0), "stall end");

    // Reset asserted after beat 2 of a data line read
    apply(mk(0,0,0, 1,1,A_X, 1, 0,0,0,0,      0,0,0,0,   0,0, 0,0,0,0, 0,0), "rst idle");
    apply(mk(0,0,0, 1,1,A_X, 1, 0,0,0,0,      1,A_X,3,1, 0,1, 0,0,0,0, 0,1), "rst ar");
    apply(mk(0,0,0, 0,0,0,   0, 1,1,32'h01,0, 0,0,0,0,   0,0, 0,0,1,0, 1,1), "rst beat1");
    apply(mk(0,0,0, 0,0,0,   0, 1,1,32'h02,0, 0,0,0,0,   0,0, 0,0,1,0, 1,1), "rst beat2");
    data_rd_req = 0; rvalid = 1; rid = 1; rdata = 32'h03; rlast = 0;
    reset = 1'b1;
    #2;
    chk("midrst arvalid", 32'(arvalid), 0);
    chk("midrst rready",  32'(rready),  0);
    chk("midrst retv",    32'({inst_ret_valid, data_ret_valid}), 0);
    chk("midrst busy",    32'(busy),    0);
    @(negedge clk);
    reset = 1'b0;
    rvalid = 0;
    @(posedge clk);
    #1;
    apply(mk(1,0,A_N, 0,0,0, 1, 0,0,0,0,       0,0,0,0,   0,0, 0,0,0,0, 0,0), "post idle");
    apply(mk(1,0,A_N, 0,0,0, 1, 0,0,0,0,       1,A_N,0,0, 1,0, 0,0,0,0, 0,1), "post ar");
    apply(mk(0,0,0,   0,0,0, 0, 1,0,32'hDD,1,  0,0,0,0,   0,0, 1,1,0,0, 1,1), "post beat");

    // Data-only grant, then a tie: round-robin picks inst, fixed priority picks data
    apply(mk(0,0,0, 1,0,32'h2000, 1, 0,0,0,0,  0,0,0,0,         0,0, 0,0,0,0, 0,0), "rr d idle");
    apply(mk(0,0,0, 1,0,32'h2000, 1, 0,0,0,0,  1,32'h2000,0,1,  0,1, 0,0,0,0, 0,1), "rr d ar");
    apply(mk(0,0,0, 0,0,0,        0, 1,1,32'hE1,1, 0,0,0,0,     0,0, 0,0,1,1, 1,1), "rr d beat");
    apply(mk(1,0,A_RI, 1,0,A_RD, 1, 0,0,0,0,   0,0,0,0,         0,0, 0,0,0,0, 0,0), "rr tie idle");
    if (rr_inst_first) begin
      apply(mk(1,0,A_RI, 1,0,A_RD, 1, 0,0,0,0,     1,A_RI,0,0, 1,0, 0,0,0,0, 0,1), "rr tie ar");
      apply(mk(0,0,0,    1,0,A_RD, 0, 1,0,32'hE2,1, 0,0,0,0,   0,0, 1,1,0,0, 1,1), "rr tie beat");
      apply(mk(0,0,0,    1,0,A_RD, 1, 0,0,0,0,     0,0,0,0,    0,0, 0,0,0,0, 0,0), "rr lose idle");
      apply(mk(0,0,0,    1,0,A_RD, 1, 0,0,0,0,     1,A_RD,0,1, 0,1, 0,0,0,0, 0,1), "rr lose ar");
    end else begin
      apply(mk(1,0,A_RI, 1,0,A_RD, 1, 0,0,0,0,     1,A_RD,0,1, 0,1, 0,0,0,0, 0,1), "rr tie ar");
      apply(mk(1,0,A_RI, 0,0,0,    0, 1,1,32'hE2,1, 0,0,0,0,   0,0, 0,0,1,1, 1,1), "rr tie beat");
      apply(mk(1,0,A_RI, 0,0,0,    1, 0,0,0,0,     0,0,0,0,    0,0, 0,0,0,0, 0,0), "rr lose idle");
      apply(mk(1,0,A_RI, 0,0,0,    1, 0,0,0,0,     1,A_RI,0,0, 1,0, 0,0,0,0, 0,1), "rr lose ar");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
